// File: rtl/pe_fp_ctrl.sv
// pe_fp_ctrl: sequencer for one fused conv/pool/binarize processing element.
// Walks filter (outer), pooled row, pooled column (inner). For each output
// position it fetches the window, runs the PE for PE_LAT cycles, captures the
// binarized bit and pool index, then writes it out through valid/ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a layer (sampled only in IDLE)
//   busy, done            layer status; done is a one-cycle pulse
//   w_req/w_addr/w_ack    weight load handshake (w_addr = filter index)
//   win_req/win_row/win_col/win_ack  window fetch handshake
//   pe_en                 PE enable, held PE_LAT cycles per output
//   pe_bit, pe_pindex     PE result inputs
//   out_valid/out_ready   output buffer handshake
//   out_data/out_pindex/out_addr  captured result and its linear address
module pe_fp_ctrl #(
  parameter int OUT_H        = 4,
  parameter int OUT_W        = 4,
  parameter int N_FILTER     = 8,
  parameter int PE_LAT       = 2,
  parameter int PINDEX_WIDTH = 2,
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int FW = (N_FILTER > 1) ? $clog2(N_FILTER) : 1,
  localparam int AW = (N_FILTER * OUT_H * OUT_W > 1) ? $clog2(N_FILTER * OUT_H * OUT_W) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    w_req,
  output logic [FW-1:0]           w_addr,
  input  logic                    w_ack,
  output logic                    win_req,
  output logic [RW-1:0]           win_row,
  output logic [CW-1:0]           win_col,
  input  logic                    win_ack,
  output logic                    pe_en,
  input  logic                    pe_bit,
  input  logic [PINDEX_WIDTH-1:0] pe_pindex,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_data,
  output logic [PINDEX_WIDTH-1:0] out_pindex,
  output logic [AW-1:0]           out_addr
);

  localparam int LW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FETCH,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [FW-1:0]           f_q, f_d;
  logic [RW-1:0]           r_q, r_d;
  logic [CW-1:0]           c_q, c_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic                    data_q, data_d;
  logic [PINDEX_WIDTH-1:0] pidx_q, pidx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      data_q  <= 1'b0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      r_q     <= r_d;
      c_q     <= c_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      pidx_q  <= pidx_d;
    end
  end

  // Outputs are decoded from registered state only, so they move on clock edges.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign w_req      = (state_q == LOAD_W);
  assign win_req    = (state_q == FETCH);
  assign pe_en      = (state_q == COMPUTE);
  assign out_valid  = (state_q == WRITE);
  assign w_addr     = f_q;
  assign win_row    = r_q;
  assign win_col    = c_q;
  assign out_data   = data_q;
  assign out_pindex = pidx_q;
  assign out_addr   = addr_q;

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    r_d     = r_q;
    c_d     = c_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    data_d  = data_q;
    pidx_d  = pidx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          f_d     = '0;
          r_d     = '0;
          c_d     = '0;
          addr_d  = '0;
          state_d = LOAD_W;
        end
      end

      LOAD_W: begin
        if (w_ack) state_d = FETCH;
      end

      FETCH: begin
        if (win_ack) begin
          lat_d   = '0;
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        // Capture in the final enabled cycle; the PE result is valid then.
        if (lat_q == LW'(PE_LAT - 1)) begin
          data_d  = pe_bit;
          pidx_d  = pe_pindex;
          state_d = WRITE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      WRITE: begin
        if (out_ready) begin
          addr_d = addr_q + 1'b1;
          if (c_q != CW'(OUT_W - 1)) begin
            c_d     = c_q + 1'b1;
            state_d = FETCH;
          end else begin
            c_d = '0;
            if (r_q != RW'(OUT_H - 1)) begin
              r_d     = r_q + 1'b1;
              state_d = FETCH;
            end else begin
              r_d = '0;
              if (f_q != FW'(N_FILTER - 1)) begin
                // New filter: weights must be reloaded before the next fetch.
                f_d     = f_q + 1'b1;
                state_d = LOAD_W;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule
